// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline interlock for a 5-stage MIPS-style core.
//
// Raises a stall when the D-stage instruction needs an operand sooner than
// an older instruction in E or M can produce it (tuse < tnew). It also
// stalls a HI/LO instruction while the multiply/divide unit is busy.
// A stall freezes PC and IF/ID and inserts a bubble into ID/EX.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   d_rs_addr/d_rt_addr      D-stage source registers
//   d_rs_tuse/d_rt_tuse      cycles until D needs the operand (3 = unused)
//   e_wr_addr/m_wr_addr      E/M destination registers
//   e_tnew/m_tnew            cycles until the E/M result is available
//   d_is_md                  D instruction uses the HI/LO unit
//   e_md_start, e_md_is_div  mult/div issuing in E; divide if high
//   pc_en, fd_en, de_flush   pipeline register controls
//   md_busy                  HI/LO unit busy
//   stall_cnt                (only with STALL_PERF_CNT_EN) count of stall cycles
//
// Optional feature macro: STALL_PERF_CNT_EN adds the 32-bit stall_cnt output.
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic [4:0]  e_wr_addr,
  input  logic [4:0]  m_wr_addr,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        d_is_md,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_flush,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        md_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] busy_cnt;
  logic          rs_hazard;
  logic          rt_hazard;
  logic          data_hazard;
  logic          md_hazard;
  logic          stall;

  // A source with tuse = 3 can never satisfy tuse < tnew, but it is excluded
  // explicitly so the intent does not depend on the 2-bit encoding.
  assign rs_hazard = (d_rs_addr != 5'd0) && (d_rs_tuse != 2'd3) &&
                     (((d_rs_addr == e_wr_addr) && (d_rs_tuse < e_tnew)) ||
                      ((d_rs_addr == m_wr_addr) && (d_rs_tuse < m_tnew)));

  assign rt_hazard = (d_rt_addr != 5'd0) && (d_rt_tuse != 2'd3) &&
                     (((d_rt_addr == e_wr_addr) && (d_rt_tuse < e_tnew)) ||
                      ((d_rt_addr == m_wr_addr) && (d_rt_tuse < m_tnew)));

  assign data_hazard = rs_hazard || rt_hazard;
  assign md_busy     = (busy_cnt != '0);
  assign md_hazard   = d_is_md && (md_busy || e_md_start);

  // Reset masks the stall so the front end keeps moving during reset.
  assign stall    = !reset && (data_hazard || md_hazard);
  assign pc_en    = !stall;
  assign fd_en    = !stall;
  assign de_flush = stall;

  // A start while busy is ignored: the running count is neither reloaded nor extended.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt <= '0;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CW'(1);
    end else if (e_md_start) begin
      busy_cnt <= e_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, e_wr_addr, m_wr_addr;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        pc_en, fd_en, de_flush, md_busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .e_wr_addr(e_wr_addr), .m_wr_addr(m_wr_addr),
    .e_tnew(e_tnew), .m_tnew(m_tnew),
    .d_is_md(d_is_md), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .pc_en(pc_en), .fd_en(fd_en), .de_flush(de_flush),
`ifdef STALL_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .md_busy(md_busy)
  );

  typedef struct {
    logic [4:0] rs, rt, ew, mw;
    logic [1:0] rs_tuse, rt_tuse, etn, mtn;
    logic       is_md;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {pc_en, fd_en, de_flush}
  task automatic chk_stall(input string name, input logic s);
    chk(name, {29'd0, pc_en, fd_en, de_flush}, s ? 32'b001 : 32'b110);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    d_rs_addr = 0; d_rt_addr = 0; d_rs_tuse = 3; d_rt_tuse = 3;
    e_wr_addr = 0; m_wr_addr = 0; e_tnew = 0; m_tnew = 0;
    d_is_md = 0; e_md_start = 0; e_md_is_div = 0;
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] rs_tuse,
                              input logic [4:0] rt, input logic [1:0] rt_tuse,
                              input logic [4:0] ew, input logic [1:0] etn,
                              input logic [4:0] mw, input logic [1:0] mtn,
                              input logic is_md, input logic exp_stall);
    vec_t v;
    v.rs = rs; v.rs_tuse = rs_tuse; v.rt = rt; v.rt_tuse = rt_tuse;
    v.ew = ew; v.etn = etn; v.mw = mw; v.mtn = mtn;
    v.is_md = is_md; v.exp_stall = exp_stall;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(8, 0,  0, 3,  8, 1,  0, 0, 0, 1); // rs=8 tuse0 vs E tnew1
    vecs[1] = mk(0, 0,  0, 3,  0, 2,  0, 0, 0, 0); // $0 never hazards
    vecs[2] = mk(8, 1,  0, 3,  8, 1,  0, 0, 0, 0); // tuse == tnew
    vecs[3] = mk(0, 3,  9, 0,  0, 0,  9, 1, 0, 1); // rt vs M
    vecs[4] = mk(8, 3,  0, 3,  8, 3,  0, 0, 0, 0); // tuse=3 unused
    vecs[5] = mk(5, 1,  0, 3,  6, 2,  5, 2, 0, 1); // rs vs M only
    vecs[6] = mk(5, 2,  0, 3,  5, 1,  0, 0, 0, 0); // tuse > tnew
    vecs[7] = mk(0, 3, 31, 0, 31, 2,  0, 0, 0, 1); // rt vs E, reg 31
    vecs[8] = mk(3, 0,  0, 3,  4, 2,  5, 2, 0, 0); // no address match
    vecs[9] = mk(0, 3,  0, 3,  0, 0,  0, 0, 1, 0); // md idle, no start

    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
    // hazard present while in reset must not stall
    d_rs_addr = 8; d_rs_tuse = 0; e_wr_addr = 8; e_tnew = 1;
    #1;
    chk_stall("reset_masks_stall", 1'b0);
    tick();
    idle_inputs();
    reset = 1'b0;

    foreach (vecs[i]) begin
      tick();
      d_rs_addr = vecs[i].rs; d_rs_tuse = vecs[i].rs_tuse;
      d_rt_addr = vecs[i].rt; d_rt_tuse = vecs[i].rt_tuse;
      e_wr_addr = vecs[i].ew; e_tnew = vecs[i].etn;
      m_wr_addr = vecs[i].mw; m_tnew = vecs[i].mtn;
      d_is_md = vecs[i].is_md;
      #1;
      chk_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
    end

    // mult: start at T, busy T+1..T+5, clear at T+6; d_is_md stalls T..T+5
    tick(); idle_inputs();
    e_md_start = 1; e_md_is_div = 0; d_is_md = 1;
    #1;
    chk_stall("mult_T_stall", 1'b1);
    chk("mult_T_busy", {31'd0, md_busy}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_md_start = 0;
      #1;
      chk($sformatf("mult_busy_T+%0d", k), {31'd0, md_busy}, 32'd1);
      chk_stall($sformatf("mult_stall_T+%0d", k), 1'b1);
    end
    tick();
    #1;
    chk("mult_busy_T+6", {31'd0, md_busy}, 32'd0);
    chk_stall("mult_stall_T+6", 1'b0);

    // div with a second start 3 cycles in: busy exactly T+1..T+10
    tick(); idle_inputs();
    e_md_start = 1; e_md_is_div = 1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      e_md_start = (k == 3);
      e_md_is_div = 1'b0;
      #1;
      chk($sformatf("div2_busy_T+%0d", k), {31'd0, md_busy}, (k <= 10) ? 32'd1 : 32'd0);
    end
    idle_inputs();

    // reset at the 4th busy cycle of a div
    tick();
    e_md_start = 1; e_md_is_div = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      e_md_start = 0;
    end
    tick();
    reset = 1; d_is_md = 1;
    #1;
    chk("rst_mid_busy_still", {31'd0, md_busy}, 32'd1);
    chk_stall("rst_mid_no_stall", 1'b0);
    tick();
    reset = 0;
    #1;
    chk("rst_mid_busy_cleared", {31'd0, md_busy}, 32'd0);
    chk_stall("rst_mid_after", 1'b0);

`ifdef STALL_PERF_CNT_EN
    tick(); idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 7; k++) begin
      d_rs_addr = 8; d_rs_tuse = 0; e_wr_addr = 8; e_tnew = 1;
      tick();
    end
    idle_inputs();
    tick();
    chk("perf_stall_cnt", stall_cnt, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles after a mult/multu start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles after a div/divu start.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports d_rs_addr, d_rt_addr  input  5 each  source registers of the D-stage instruction.
REQ-006 SHALL have ports d_rs_tuse, d_rt_tuse  input  2 each  cycles until D needs the operand; 3 means not used.
REQ-007 SHALL have ports e_wr_addr, m_wr_addr  input  5 each  destination registers in E and M.
REQ-008 SHALL have ports e_tnew, m_tnew  input  2 each  cycles until the E/M result is available.
REQ-009 SHALL have port d_is_md  input  1  D instruction uses the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have ports e_md_start, e_md_is_div  input  1 each  mult/div issuing in E this cycle; divide if high.
REQ-011 SHALL have ports pc_en, fd_en  output  1 each  enables for the PC register and the IF/ID register.
REQ-012 SHALL have port de_flush  output  1  inserts a bubble into the ID/EX register.
REQ-013 SHALL have port md_busy  output  1  HI/LO unit is busy.

Function
REQ-014 SHALL assert data_hazard when, for rs or rt, the address is nonzero and tuse < tnew for a matching E or M destination.
REQ-015 SHALL ignore address 0 and tuse = 3 when detecting hazards.
REQ-016 SHALL assert md_hazard when d_is_md is high and either md_busy or e_md_start is high.
REQ-017 SHALL compute stall = data_hazard OR md_hazard combinationally, with zero-cycle latency.
REQ-018 SHALL drive pc_en = fd_en = NOT stall and de_flush = stall.
REQ-019 SHALL hold a busy counter; on e_md_start with counter 0, it loads DIV_CYCLES if e_md_is_div else MULT_CYCLES.
REQ-020 SHALL decrement a nonzero counter by 1 each cycle and saturate at 0.
REQ-021 SHALL drive md_busy high from the cycle after e_md_start for exactly the loaded count of cycles.
REQ-022 SHALL ignore e_md_start while the counter is nonzero; the count is not reloaded or extended.
REQ-023 SHALL size the counter to hold max(MULT_CYCLES, DIV_CYCLES) without wrap-around.

Reset
REQ-024 SHALL, when reset is high at a clock edge, clear the counter, so md_busy = 0 the next cycle.
REQ-025 SHALL, while reset is high, force stall = 0 (pc_en = 1, fd_en = 1, de_flush = 0), including when reset occurs mid-operation.

Configuration
REQ-026 SHALL, with STALL_PERF_CNT_EN defined, add output stall_cnt (32 bit), cleared by reset and incremented on each stall cycle, wrapping from 0xFFFFFFFF to 0.
REQ-027 SHALL, without STALL_PERF_CNT_EN, have no stall_cnt port and no counter logic; other behaviour is identical.

Verification
REQ-028 SHALL cover: D rs=8 with tuse=0, and E wr=8 with tnew=1 -> pc_en=0, fd_en=0, de_flush=1 in the same cycle.
REQ-029 SHALL cover: D rs=0 with tuse=0, and E wr=0 with tnew=2 -> no stall (pc_en=1, de_flush=0).
REQ-030 SHALL cover: e_md_start=1, e_md_is_div=0 at cycle T -> md_busy=1 for cycles T+1..T+5 and 0 at T+6; d_is_md=1 during T..T+5 -> stall.
REQ-031 SHALL cover: div start, then a second start 3 cycles later -> second start ignored; md_busy lasts exactly 10 cycles.
REQ-032 SHALL cover: reset asserted at the 4th busy cycle of a div -> md_busy=0 the next cycle and stall=0 during reset.
REQ-033 SHALL cover: with STALL_PERF_CNT_EN defined, 7 stall cycles after reset -> stall_cnt=7.
